// File: rtl/ecc_dec.sv
// SECDED (72,64) Hamming decoder: recomputes parity over a received
// 64-bit word and its check byte, corrects single-bit errors, flags uncorrectable ones.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   valid_in         data_in/ecc_in valid this cycle
//   data_in[63:0]    received data
//   ecc_in[7:0]      received check byte ([6:0] Hamming p0..p6, [7] overall)
//   clr_cnt          synchronous clear of the error counters
//   valid_out        outputs valid (2 cycles after valid_in)
//   data_out[63:0]   corrected data
//   err_ce / err_ue  correctable / uncorrectable error
//   err_syn[7:0]     {overall_check, syndrome[6:0]}
//   ce_cnt / ue_cnt  saturating error counters (ECC_DEC_CNT_EN only)
//
// Optional feature macro: ECC_DEC_CNT_EN enables the error counters.

module ecc_dec #(
    parameter int CNT_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_in,
    input  logic [63:0] data_in,
    input  logic [7:0]  ecc_in,
    input  logic        clr_cnt,
    output logic        valid_out,
    output logic [63:0] data_out,
    output logic        err_ce,
    output logic        err_ue,
    output logic [7:0]  err_syn
`ifdef ECC_DEC_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] ce_cnt,
    output logic [CNT_WIDTH-1:0] ue_cnt
`endif
);

    // Codeword position of data bit j (parity bits occupy the powers of two).
    function automatic logic [6:0] dpos(input int j);
        if (j < 1)       return 7'd3;
        else if (j < 4)  return 7'(j + 4);
        else if (j < 11) return 7'(j + 5);
        else if (j < 26) return 7'(j + 6);
        else if (j < 57) return 7'(j + 7);
        else             return 7'(j + 8);
    endfunction

    logic        v1_q, v1_d;
    logic [63:0] data1_q, data1_d;
    logic [6:0]  syn1_q, syn1_d;
    logic        ovr1_q, ovr1_d;

    logic        valid_out_q, valid_out_d;
    logic [63:0] data_out_q, data_out_d;
    logic        err_ce_q, err_ce_d;
    logic        err_ue_q, err_ue_d;
    logic [7:0]  err_syn_q, err_syn_d;

    logic [6:0]  syn_calc;
    logic [63:0] fix_mask;
    logic        is_ce;
    logic        is_ue;

    // Stage 1: syndrome is the received parity XOR the recomputed parity,
    // i.e. the XOR of the positions of every set data bit folded into ecc_in.
    always_comb begin
        syn_calc = ecc_in[6:0];
        for (int j = 0; j < 64; j++) begin
            if (data_in[j]) syn_calc = syn_calc ^ dpos(j);
        end
    end

    always_comb begin
        v1_d    = valid_in;
        data1_d = data1_q;
        syn1_d  = syn1_q;
        ovr1_d  = ovr1_q;
        if (valid_in) begin
            data1_d = data_in;
            syn1_d  = syn_calc;
            ovr1_d  = ecc_in[7] ^ (^data_in) ^ (^ecc_in[6:0]);
        end
    end

    // Stage 2: an odd overall check with a syndrome inside the codeword is a
    // single error; only syndromes that hit a data position flip a data bit.
    always_comb begin
        for (int j = 0; j < 64; j++) begin
            fix_mask[j] = ovr1_q && (syn1_q == dpos(j));
        end
        is_ce = ovr1_q && (syn1_q <= 7'd71);
        is_ue = ovr1_q ? (syn1_q > 7'd71) : (syn1_q != 7'd0);
    end

    always_comb begin
        valid_out_d = v1_q;
        data_out_d  = data_out_q;
        err_syn_d   = err_syn_q;
        err_ce_d    = 1'b0;
        err_ue_d    = 1'b0;
        if (v1_q) begin
            data_out_d = data1_q ^ fix_mask;
            err_syn_d  = {ovr1_q, syn1_q};
            err_ce_d   = is_ce;
            err_ue_d   = is_ue;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q        <= 1'b0;
            data1_q     <= '0;
            syn1_q      <= '0;
            ovr1_q      <= 1'b0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            err_ce_q    <= 1'b0;
            err_ue_q    <= 1'b0;
            err_syn_q   <= '0;
        end else begin
            v1_q        <= v1_d;
            data1_q     <= data1_d;
            syn1_q      <= syn1_d;
            ovr1_q      <= ovr1_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            err_ce_q    <= err_ce_d;
            err_ue_q    <= err_ue_d;
            err_syn_q   <= err_syn_d;
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign err_ce    = err_ce_q;
    assign err_ue    = err_ue_q;
    assign err_syn   = err_syn_q;

`ifdef ECC_DEC_CNT_EN
    logic [CNT_WIDTH-1:0] ce_cnt_q, ce_cnt_d;
    logic [CNT_WIDTH-1:0] ue_cnt_q, ue_cnt_d;

    // Clear beats increment; counters stick at all-ones.
    always_comb begin
        ce_cnt_d = ce_cnt_q;
        ue_cnt_d = ue_cnt_q;
        if (clr_cnt) begin
            ce_cnt_d = '0;
            ue_cnt_d = '0;
        end else begin
            if (valid_out_q && err_ce_q && (ce_cnt_q != '1))
                ce_cnt_d = ce_cnt_q + 1'b1;
            if (valid_out_q && err_ue_q && (ue_cnt_q != '1))
                ue_cnt_d = ue_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ce_cnt_q <= '0;
            ue_cnt_q <= '0;
        end else begin
            ce_cnt_q <= ce_cnt_d;
            ue_cnt_q <= ue_cnt_d;
        end
    end

    assign ce_cnt = ce_cnt_q;
    assign ue_cnt = ue_cnt_q;
`else
    localparam int unused_cnt_width = CNT_WIDTH;
    logic unused_clr;
    assign unused_clr = clr_cnt;
`endif

endmodule

// File: tb/tb_ecc_dec.sv
// Testbench for ecc_dec: directed vectors, randomized back-to-back stream
// against a codeword-level reference model, reset mid-stream, optional counters.

module tb_ecc_dec;

`ifdef ECC_DEC_CNT_EN
    localparam int CW = 2;
`else
    localparam int CW = 16;
`endif

    logic        clk;
    logic        rstn;
    logic        valid_in;
    logic [63:0] data_in;
    logic [7:0]  ecc_in;
    logic        clr_cnt;
    logic        valid_out;
    logic [63:0] data_out;
    logic        err_ce;
    logic        err_ue;
    logic [7:0]  err_syn;
`ifdef ECC_DEC_CNT_EN
    logic [CW-1:0] ce_cnt;
    logic [CW-1:0] ue_cnt;
`endif

    int vecs = 0;
    int errs = 0;
    logic [63:0] hold_d;
    logic [7:0]  hold_s;

    ecc_dec #(.CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ecc_in    (ecc_in),
        .clr_cnt   (clr_cnt),
        .valid_out (valid_out),
        .data_out  (data_out),
        .err_ce    (err_ce),
        .err_ue    (err_ue),
        .err_syn   (err_syn)
`ifdef ECC_DEC_CNT_EN
        ,
        .ce_cnt    (ce_cnt),
        .ue_cnt    (ue_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build the 72-bit codeword array (position 0 = overall parity), then
    // syndrome = XOR of the indices of all set positions.
    task automatic model(input logic [63:0] d, input logic [7:0] e,
                         output logic [63:0] dout, output logic ce,
                         output logic ue, output logic [7:0] syn);
        logic [71:0] cw;
        int k, pi, s;
        logic ov;
        cw = '0;
        cw[0] = e[7];
        k = 0;
        pi = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) == 0) begin
                cw[p] = e[pi];
                pi++;
            end else begin
                cw[p] = d[k];
                k++;
            end
        end
        s = 0;
        ov = 1'b0;
        for (int p = 0; p < 72; p++) begin
            if (cw[p]) begin
                s = s ^ p;
                ov = ~ov;
            end
        end
        syn = {ov, s[6:0]};
        ce = 1'b0;
        ue = 1'b0;
        if (ov && s <= 71) begin
            ce = 1'b1;
            if (s != 0) cw[s] = ~cw[s];
        end else if (ov || s != 0) begin
            ue = 1'b1;
        end
        k = 0;
        dout = '0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                dout[k] = cw[p];
                k++;
            end
        end
    endtask

    task automatic encode(input logic [63:0] d, output logic [7:0] e);
        int s;
        int k;
        s = 0;
        k = 0;
        for (int p = 1; p < 72; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (d[k]) s = s ^ p;
                k++;
            end
        end
        e[6:0] = s[6:0];
        e[7] = (^d) ^ (^e[6:0]);
    endtask

    task automatic gen_word(output logic [63:0] d, output logic [7:0] e);
        logic [71:0] cw;
        int kind, r1, r2;
        d = {$urandom, $urandom};
        encode(d, e);
        cw = {e, d};
        kind = $urandom_range(0, 9);
        r1 = $urandom_range(0, 71);
        r2 = (r1 + $urandom_range(1, 71)) % 72;
        if (kind >= 4) cw[r1] = ~cw[r1];
        if (kind == 8) cw[r2] = ~cw[r2];
        if (kind == 9) cw[71:64] = 8'($urandom);
        d = cw[63:0];
        e = cw[71:64];
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        valid_in = 1'b0;
        data_in = '0;
        ecc_in = '0;
        clr_cnt = 1'b0;
        #12;
        vecs++;
        if (valid_out !== 1'b0 || data_out !== 64'h0 || err_ce !== 1'b0 ||
            err_ue !== 1'b0 || err_syn !== 8'h00) begin
            errs++;
            $display("FAIL reset: v=%b d=%h ce=%b ue=%b syn=%h, want all 0",
                     valid_out, data_out, err_ce, err_ue, err_syn);
        end
`ifdef ECC_DEC_CNT_EN
        vecs++;
        if (ce_cnt !== '0 || ue_cnt !== '0) begin
            errs++;
            $display("FAIL reset_cnt: ce=%0d ue=%0d, want 0 0", ce_cnt, ue_cnt);
        end
`endif
        hold_d = '0;
        hold_s = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_directed();
        logic [63:0] td [7];
        logic [7:0]  te [7];
        logic [63:0] xd [7];
        logic        xc [7];
        logic        xu [7];
        logic [7:0]  xs [7];
        td = '{64'h0, 64'h1, 64'h3, 64'h0, 64'h0, 64'h8000_0000_0000_0000, 64'h0};
        te = '{8'h00, 8'h00, 8'h00, 8'h80, 8'hC8, 8'h00, 8'h08};
        xd = '{64'h0, 64'h0, 64'h3, 64'h0, 64'h0, 64'h0, 64'h0};
        xc = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        xu = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        xs = '{8'h00, 8'h83, 8'h06, 8'h80, 8'hC8, 8'hC7, 8'h88};
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b1;
            data_in = td[i];
            ecc_in = te[i];
            @(posedge clk); #1;
            valid_in = 1'b0;
            @(posedge clk); #1;
            vecs++;
            if (valid_out !== 1'b1 || data_out !== xd[i] || err_ce !== xc[i] ||
                err_ue !== xu[i] || err_syn !== xs[i]) begin
                errs++;
                $display("FAIL directed[%0d]: v=%b d=%h ce=%b ue=%b syn=%h, want 1 %h %b %b %h",
                         i, valid_out, data_out, err_ce, err_ue, err_syn,
                         xd[i], xc[i], xu[i], xs[i]);
            end
            hold_d = xd[i];
            hold_s = xs[i];
        end
        @(posedge clk); #1;
        vecs++;
        if (valid_out !== 1'b0 || err_ce !== 1'b0 || err_ue !== 1'b0 ||
            data_out !== hold_d || err_syn !== hold_s) begin
            errs++;
            $display("FAIL idle_hold: v=%b ce=%b ue=%b d=%h syn=%h, want 0 0 0 %h %h",
                     valid_out, err_ce, err_ue, data_out, err_syn, hold_d, hold_s);
        end
    endtask

    task automatic test_back_to_back();
        localparam int N = 300;
        logic        hv [N];
        logic [63:0] hd [N];
        logic        hc [N];
        logic        hu [N];
        logic [7:0]  hs [N];
        logic [63:0] d;
        logic [7:0]  e;
        for (int i = 0; i < N + 2; i++) begin
            @(posedge clk); #1;
            if (i >= 2) begin
                int j;
                j = i - 2;
                if (hv[j]) begin
                    hold_d = hd[j];
                    hold_s = hs[j];
                end
                vecs++;
                if (valid_out !== hv[j] || data_out !== hold_d ||
                    err_ce !== (hv[j] & hc[j]) || err_ue !== (hv[j] & hu[j]) ||
                    err_syn !== hold_s) begin
                    errs++;
                    $display("FAIL b2b[%0d]: v=%b d=%h ce=%b ue=%b syn=%h, want %b %h %b %b %h",
                             j, valid_out, data_out, err_ce, err_ue, err_syn,
                             hv[j], hold_d, hv[j] & hc[j], hv[j] & hu[j], hold_s);
                end
            end
            if (i < N) begin
                gen_word(d, e);
                hv[i] = ($urandom_range(0, 4) != 0);
                model(d, e, hd[i], hc[i], hu[i], hs[i]);
                valid_in = hv[i];
                data_in = d;
                ecc_in = e;
            end else begin
                valid_in = 1'b0;
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] d;
        logic [7:0]  e;
        logic [63:0] md;
        logic        mc, mu;
        logic [7:0]  ms;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            gen_word(d, e);
            valid_in = 1'b1;
            data_in = d;
            ecc_in = e;
        end
        #2;
        rstn = 1'b0;
        valid_in = 1'b0;
        #1;
        vecs++;
        if (valid_out !== 1'b0 || data_out !== 64'h0 || err_ce !== 1'b0 ||
            err_ue !== 1'b0 || err_syn !== 8'h00) begin
            errs++;
            $display("FAIL midreset: v=%b d=%h ce=%b ue=%b syn=%h, want all 0",
                     valid_out, data_out, err_ce, err_ue, err_syn);
        end
`ifdef ECC_DEC_CNT_EN
        vecs++;
        if (ce_cnt !== '0 || ue_cnt !== '0) begin
            errs++;
            $display("FAIL midreset_cnt: ce=%0d ue=%0d, want 0 0", ce_cnt, ue_cnt);
        end
`endif
        hold_d = '0;
        hold_s = '0;
        @(negedge clk);
        rstn = 1'b1;
        gen_word(d, e);
        model(d, e, md, mc, mu, ms);
        @(posedge clk); #1;
        valid_in = 1'b1;
        data_in = d;
        ecc_in = e;
        for (int c = 1; c <= 2; c++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
            if (c == 1) begin
                vecs++;
                if (valid_out !== 1'b0) begin
                    errs++;
                    $display("FAIL postreset_lat1: v=%b, want 0", valid_out);
                end
            end else begin
                vecs++;
                if (valid_out !== 1'b1 || data_out !== md || err_ce !== mc ||
                    err_ue !== mu || err_syn !== ms) begin
                    errs++;
                    $display("FAIL postreset_word: v=%b d=%h ce=%b ue=%b syn=%h, want 1 %h %b %b %h",
                             valid_out, data_out, err_ce, err_ue, err_syn, md, mc, mu, ms);
                end
                hold_d = md;
                hold_s = ms;
            end
        end
        @(posedge clk); #1;
    endtask

`ifdef ECC_DEC_CNT_EN
    task automatic test_counters();
        @(posedge clk); #1;
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        vecs++;
        if (ce_cnt !== '0 || ue_cnt !== '0) begin
            errs++;
            $display("FAIL cnt_clr: ce=%0d ue=%0d, want 0 0", ce_cnt, ue_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            valid_in = 1'b1;
            data_in = 64'h1;
            ecc_in = 8'h00;
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
        data_in = 64'h3;
        ecc_in = 8'h00;
        repeat (4) @(posedge clk);
        #1;
        vecs++;
        if (ce_cnt !== 2'b11 || ue_cnt !== 2'b00) begin
            errs++;
            $display("FAIL cnt_sat: ce=%0d ue=%0d, want 3 0", ce_cnt, ue_cnt);
        end
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (ue_cnt !== 2'b01 || ce_cnt !== 2'b11) begin
            errs++;
            $display("FAIL cnt_ue: ce=%0d ue=%0d, want 3 1", ce_cnt, ue_cnt);
        end
        valid_in = 1'b1;
        data_in = 64'h1;
        ecc_in = 8'h00;
        @(posedge clk); #1;
        valid_in = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if (valid_out !== 1'b1 || err_ce !== 1'b1) begin
            errs++;
            $display("FAIL cnt_ce_word: v=%b ce=%b, want 1 1", valid_out, err_ce);
        end
        clr_cnt = 1'b1;
        @(posedge clk); #1;
        clr_cnt = 1'b0;
        vecs++;
        if (ce_cnt !== 2'b00 || ue_cnt !== 2'b00) begin
            errs++;
            $display("FAIL cnt_clr_wins: ce=%0d ue=%0d, want 0 0", ce_cnt, ue_cnt);
        end
        hold_d = 64'h0;
        hold_s = 8'h83;
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
`ifdef ECC_DEC_CNT_EN
        test_counters();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
